// File: rtl/truth_table_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_scanner_pkg
// Brief    : Shared state encoding, default sizes and helpers for the scanner.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_scanner_pkg;

    localparam int c_DEF_N_IN   = 4;
    localparam int c_DEF_N_OUT  = 3;
    localparam int c_DEF_SETTLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

    // Settle counter runs 0..settle-1, so it never needs more than clog2(settle) bits.
    function automatic int settle_cnt_w(input int settle);
        return (settle <= 2) ? 1 : $clog2(settle);
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_scanner_tt_mem.sv
`default_nettype none
// ============================================================================
// Module   : tt_mem
// Brief    : Expected-response table, one synchronous write, one async read.
// Revision : 1.0 - initial release
// ============================================================================
module tt_mem #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [N_IN-1:0]  waddr_i,
    input  logic [N_OUT-1:0] wdata_i,
    input  logic [N_IN-1:0]  raddr_i,
    output logic [N_OUT-1:0] rdata_o
);

    // Contents deliberately survive reset so a loaded table can be rescanned.
    logic [N_OUT-1:0] mem_q [2**N_IN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_scanner
// Brief    : Walks every input vector, compares DUT response to a stored table.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_IN   = c_DEF_N_IN,
    parameter int N_OUT  = c_DEF_N_OUT,
    parameter int SETTLE = c_DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             tbl_we,
    input  logic [N_IN-1:0]  tbl_addr,
    input  logic [N_OUT-1:0] tbl_data,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail,
    output logic             fail_seen
);

    localparam int              CNT_W    = settle_cnt_w(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_VEC = '1;

    scan_state_t      state_q, state_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN:0]    err_q, err_d;
    logic [N_IN-1:0]  ff_q, ff_d;
    logic             fs_q, fs_d;
    logic             pass_q, pass_d;

    logic [N_OUT-1:0] w_exp_resp;
    logic             w_mismatch;
    logic             w_tbl_we;

    // Table is only writable while idle so a running scan sees a frozen image.
    assign w_tbl_we = tbl_we && (state_q == ST_IDLE);

    tt_mem #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_tt_mem (
        .clk     (clk),
        .we_i    (w_tbl_we),
        .waddr_i (tbl_addr),
        .wdata_i (tbl_data),
        .raddr_i (stim_q),
        .rdata_o (w_exp_resp)
    );

    assign w_mismatch = (resp != w_exp_resp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fs_d    = fs_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    stim_d  = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fs_d    = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (w_mismatch) begin
                        err_d = err_q + (N_IN + 1)'(1);
                        if (!fs_q) begin
                            ff_d = stim_q;
                            fs_d = 1'b1;
                        end
                    end
                    if (stim_q == LAST_VEC) begin
                        state_d = ST_DONE;
                        // Verdict includes the final vector sampled this cycle.
                        pass_d  = (err_q == '0) && !w_mismatch;
                    end else begin
                        state_d = ST_SETTLE;
                        stim_d  = stim_q + N_IN'(1);
                        cnt_d   = '0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stim       = stim_q;
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_seen  = fs_q;

endmodule
`default_nettype wire

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter N_IN, default 4: DUT input count; scan covers 2^N_IN vectors.
REQ-002 Parameter N_OUT, default 3: DUT output count.
REQ-003 Parameter SETTLE, default 1, legal range >= 1: settle cycles per vector before sampling.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  scan request, sampled in IDLE only.
REQ-007 abort  input  1  cancels a running scan.
REQ-008 tbl_we  input  1  expected-table write enable.
REQ-009 tbl_addr  input  N_IN  expected-table write address.
REQ-010 tbl_data  input  N_OUT  expected-table write data.
REQ-011 resp  input  N_OUT  DUT outputs under test.
REQ-012 stim  output  N_IN  vector driven to DUT inputs.
REQ-013 busy  output  1  high while scanning.
REQ-014 done  output  1  one-cycle pulse on scan completion.
REQ-015 pass  output  1  high when the last completed scan had zero mismatches.
REQ-016 err_count  output  N_IN+1  mismatch count of current/last scan.
REQ-017 first_fail  output  N_IN  lowest vector address that mismatched.
REQ-018 fail_seen  output  1  first_fail holds valid data.

Function
REQ-019 States: IDLE, SETTLE, SAMPLE, DONE.
REQ-020 IDLE + start=1: next cycle state SETTLE, stim=0, busy=1, err_count=0, fail_seen=0, pass=0.
REQ-021 SETTLE: remains exactly SETTLE cycles, then SAMPLE; stim stable throughout.
REQ-022 SAMPLE (one cycle): resp compared against expected[stim]; on mismatch err_count increments and, if fail_seen=0, first_fail<=stim, fail_seen<=1.
REQ-023 SAMPLE with stim < 2^N_IN-1: stim increments, state SETTLE; with stim = 2^N_IN-1: state DONE, stim held.
REQ-024 DONE (one cycle): done=1, busy=0, pass=(err_count==0); then IDLE.
REQ-025 Latency: done asserted exactly 2^N_IN*(SETTLE+1)+1 cycles after the cycle start was sampled (33 for defaults).
REQ-026 err_count cannot overflow (max 2^N_IN fits N_IN+1 bits); no saturation logic.
REQ-027 start while busy or in DONE is ignored.
REQ-028 tbl_we honoured only in IDLE; writes while busy or in DONE are discarded.
REQ-029 abort in SETTLE or SAMPLE: next cycle IDLE, busy=0, done not pulsed, pass=0, err_count/first_fail/fail_seen retain values; a mismatch in the abort cycle's SAMPLE is not counted.
REQ-030 abort and start in same IDLE cycle: start wins (abort only acts while busy).
REQ-031 pass, err_count, first_fail, fail_seen hold until next accepted start.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0, regardless of state (mid-scan included).
REQ-033 Expected-table contents are not reset; retained across rst_n.

Structure
REQ-034 Shared package holds state encoding (2-bit, IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and default N_IN/N_OUT/SETTLE constants.
REQ-035 Expected table is a sub-module tt_mem: 2^N_IN x N_OUT, one synchronous write port, one asynchronous read port addressed by stim.

Verification
REQ-036 Defaults; table loaded with correct SeisC-style function, resp looped from reference model -> done at cycle 33, pass=1, err_count=0, fail_seen=0.
REQ-037 Same, resp corrupted at stim=5 and stim=12 -> err_count=2, first_fail=5, fail_seen=1, pass=0.
REQ-038 abort asserted while stim=7 -> busy=0 next cycle, no done pulse, stim=7 held, start again rescans from stim=0.
REQ-039 rst_n=0 while stim=9 -> all outputs at reset values next cycle; table still returns loaded data on subsequent scan.
REQ-040 start re-pulsed at stim=3 and tbl_we with tbl_addr=3 during scan -> scan unaffected, table entry 3 unchanged.
REQ-041 N_IN=2, N_OUT=1, SETTLE=3 -> done 17 cycles after start; each stim value held 4 cycles.
